// File: rtl/plab5_mcore_mem_net_req_arb.sv
// plab5_mcore_mem_net_req_arb
//   Round-robin arbiter that shares one memory-request network injection port
//   between the icache (mode 0) and dcache (mode 1) refill streams.
//   The datapath is zero-latency and uses val/rdy handshakes.
//   The only state is the priority bit, the grant lock and the last issued domain.
//   Once a grant is presented and stalled, it is held until the network accepts it.
//   Optional feature: PLAB5_MCORE_MEM_NET_REQ_ARB_DOMAIN_BUBBLE_EN inserts one
//   idle cycle whenever the security domain changes between issued requests.
module plab5_mcore_mem_net_req_arb #(
    parameter int p_mem_opaque_nbits = 8,
    parameter int p_mem_addr_nbits   = 32,
    parameter int p_mem_data_nbits   = 32,
    // type(3) + opaque + addr + len + data
    localparam int MM = 3 + p_mem_opaque_nbits + p_mem_addr_nbits
                        + $clog2(p_mem_data_nbits/8) + p_mem_data_nbits
) (
    input  logic          clk_i,
    input  logic          reset_i,

    input  logic          inst_req_val_i,
    output logic          inst_req_rdy_o,
    input  logic [MM-1:0] inst_req_msg_i,
    input  logic          inst_domain_i,

    input  logic          data_req_val_i,
    output logic          data_req_rdy_o,
    input  logic [MM-1:0] data_req_msg_i,
    input  logic          data_domain_i,

    output logic          out_val_o,
    input  logic          out_rdy_i,
    output logic [MM-1:0] out_msg_o,
    output logic          out_mode_o,
    output logic          out_domain_o
);

    logic prio_q,     prio_d;
    logic lock_q,     lock_d;
    logic lock_sel_q, lock_sel_d;
    logic last_dom_q, last_dom_d;

    logic sel;
    logic cand_val;
    logic cand_dom;
    logic need_bubble;
    logic fire;

`ifdef PLAB5_MCORE_MEM_NET_REQ_ARB_DOMAIN_BUBBLE_EN
    logic bubble_q, bubble_d;
`endif

    // Pick a requester: a held grant wins; otherwise a lone requester wins;
    // otherwise the priority bit breaks the tie.
    always_comb begin
        sel = prio_q;
        if (lock_q)
            sel = lock_sel_q;
        else if (inst_req_val_i && !data_req_val_i)
            sel = 1'b0;
        else if (!inst_req_val_i && data_req_val_i)
            sel = 1'b1;

        cand_val = sel ? data_req_val_i : inst_req_val_i;
        cand_dom = sel ? data_domain_i  : inst_domain_i;

`ifdef PLAB5_MCORE_MEM_NET_REQ_ARB_DOMAIN_BUBBLE_EN
        // A domain switch costs one idle cycle. A held grant already passed its bubble.
        need_bubble = !lock_q && !bubble_q && cand_val && (cand_dom != last_dom_q);
`else
        need_bubble = 1'b0;
`endif
    end

    // Drive the output mux and the handshakes. Reset forces a quiet, inst-facing port.
    always_comb begin
        out_val_o    = cand_val && !need_bubble && !reset_i;
        out_msg_o    = (sel && !reset_i) ? data_req_msg_i : inst_req_msg_i;
        out_mode_o   = sel && !reset_i;
        out_domain_o = cand_dom && !reset_i;

        fire           = out_val_o && out_rdy_i;
        inst_req_rdy_o = fire && !sel;
        data_req_rdy_o = fire &&  sel;
    end

    // Next state for priority, lock and domain tracking.
    // A locked requester that drops val yields out_val=0, which releases the lock.
    always_comb begin
        prio_d     = fire ? !sel : prio_q;
        lock_d     = out_val_o && !out_rdy_i;
        lock_sel_d = sel;
        last_dom_d = fire ? out_domain_o : last_dom_q;
`ifdef PLAB5_MCORE_MEM_NET_REQ_ARB_DOMAIN_BUBBLE_EN
        bubble_d   = need_bubble;
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            last_dom_q <= 1'b0;
`ifdef PLAB5_MCORE_MEM_NET_REQ_ARB_DOMAIN_BUBBLE_EN
            bubble_q   <= 1'b0;
`endif
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            last_dom_q <= last_dom_d;
`ifdef PLAB5_MCORE_MEM_NET_REQ_ARB_DOMAIN_BUBBLE_EN
            bubble_q   <= bubble_d;
`endif
        end
    end

endmodule
